// File: rtl/dds_freq_meter.sv
// Frequency meter for DDS loopback: counts synchronized rising edges of
// f_in over a 2^GATE_LOG2-cycle gate and scales the count to a tuning word.
module dds_freq_meter #(
    parameter int GATE_LOG2 = 16,
    parameter int K_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_in,
    input  logic                 start,
    input  logic                 cont,
    output logic                 busy,
    output logic                 done,
    output logic [GATE_LOG2-1:0] edge_cnt,
    output logic [K_W-1:0]       K_est
);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DONE
    } state_t;

    localparam logic [GATE_LOG2-1:0] ONE = {{(GATE_LOG2-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_nxt;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 rise;
    logic                 gate_last;
    logic [GATE_LOG2-1:0] gate_cnt;
    logic [GATE_LOG2-1:0] acc;
    logic [GATE_LOG2-1:0] acc_inc;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= f_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise      = s2 & ~s3;
    assign acc_inc   = rise ? acc + ONE : acc;
    assign gate_last = (state == GATE) && (gate_cnt == '1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GATE;
                end
            end
            GATE: begin
                busy = 1'b1;
                if (gate_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = cont ? GATE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Gate and edge counters run only while gating, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt <= '0;
            acc      <= '0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + ONE;
            acc      <= acc_inc;
        end else begin
            gate_cnt <= '0;
            acc      <= '0;
        end
    end

    // Result latch; includes a rise in the final gate cycle, holds until next run
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (gate_last) begin
            edge_cnt <= acc_inc;
        end
    end

    assign K_est = K_W'(edge_cnt) << (K_W - GATE_LOG2);

endmodule
